// File: rtl/music_pkg.sv
// Shared defaults and FSM state encoding for the note slot scheduler.
package music_pkg;

    localparam int DEF_NUM_SLOTS = 3;
    localparam int DEF_NOTE_W    = 6;
    localparam int DEF_DUR_W     = 6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/slot_counter.sv
// Remaining-beat counter for one note-player slot; load beats a same-cycle beat.
module slot_counter #(
    parameter int DUR_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             load_i,
    input  logic [DUR_W-1:0] load_val_i,
    input  logic             beat_i,
    input  logic             play_i,
    output logic [DUR_W-1:0] count_o,
    output logic             busy_o,
    output logic             release_o
);

    logic [DUR_W-1:0] count_q, count_d;
    logic             tick;

    assign tick = beat_i && play_i && !flush_i && !load_i && (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (flush_i)     count_d = '0;
        else if (load_i) count_d = load_val_i;
        else if (tick)   count_d = count_q - DUR_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count_o   = count_q;
    assign busy_o    = (count_q != '0);
    // Only a natural 1 -> 0 expiry releases; a steal or flush never does.
    assign release_o = tick && (count_q == DUR_W'(1));

endmodule

// File: rtl/note_slot_scheduler.sv
// Accepts one note request at a time, allocates a player slot (stealing the
// slot closest to expiry when all are busy) and paces the song via note_done.
module note_slot_scheduler import music_pkg::*; #(
    parameter int NUM_SLOTS = DEF_NUM_SLOTS,
    parameter int NOTE_W    = DEF_NOTE_W,
    parameter int DUR_W     = DEF_DUR_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 play,
    input  logic                 beat,
    input  logic                 new_note,
    input  logic [NOTE_W-1:0]    note,
    input  logic [DUR_W-1:0]     duration,
    input  logic                 chord_next,
    output logic [NUM_SLOTS-1:0] slot_load,
    output logic [NOTE_W-1:0]    slot_note,
    output logic [DUR_W-1:0]     slot_duration,
    output logic [NUM_SLOTS-1:0] slot_busy,
    output logic [NUM_SLOTS-1:0] slot_release,
    output logic                 note_done,
    output logic                 overrun
);

    localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    state_e                        state_q, state_d;
    logic [NOTE_W-1:0]             note_q, note_d;
    logic [DUR_W-1:0]              dur_q, dur_d;
    logic                          chord_q, chord_d;
    logic [DUR_W-1:0]              gate_q, gate_d;
    logic                          overrun_q, overrun_d;

    logic [NUM_SLOTS-1:0][DUR_W-1:0] cnt;
    logic [NUM_SLOTS-1:0]          load_vec;
    logic [IDX_W-1:0]              alloc_idx;
    logic [DUR_W-1:0]              min_cnt;
    logic                          found_free;
    logic                          tick;

    assign tick = beat && play;

    // Prefer the lowest free slot; otherwise steal the smallest count.
    always_comb begin
        alloc_idx  = '0;
        found_free = 1'b0;
        min_cnt    = cnt[0];
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (!found_free && cnt[k] == '0) begin
                alloc_idx  = IDX_W'(k);
                found_free = 1'b1;
            end
        end
        if (!found_free) begin
            for (int k = 1; k < NUM_SLOTS; k++) begin
                if (cnt[k] < min_cnt) begin
                    min_cnt   = cnt[k];
                    alloc_idx = IDX_W'(k);
                end
            end
        end
    end

    assign load_vec = (state_q == S_LOAD && note_q != '0) ?
                      (NUM_SLOTS'(1) << alloc_idx) : '0;

    always_comb begin
        state_d   = state_q;
        note_d    = note_q;
        dur_d     = dur_q;
        chord_d   = chord_q;
        gate_d    = gate_q;
        overrun_d = overrun_q | (new_note && state_q != S_IDLE);
        case (state_q)
            S_IDLE: if (new_note) begin
                state_d = S_LOAD;
                note_d  = note;
                dur_d   = duration;
                chord_d = chord_next;
            end
            S_LOAD: begin
                gate_d  = dur_q;
                state_d = (chord_q || dur_q == '0) ? S_DONE : S_WAIT;
            end
            S_WAIT: if (tick) begin
                if (gate_q <= DUR_W'(1)) begin
                    gate_d  = '0;
                    state_d = S_DONE;
                end else begin
                    gate_d  = gate_q - DUR_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d   = S_IDLE;
            note_d    = '0;
            dur_d     = '0;
            chord_d   = 1'b0;
            gate_d    = '0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            note_q    <= '0;
            dur_q     <= '0;
            chord_q   <= 1'b0;
            gate_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            note_q    <= note_d;
            dur_q     <= dur_d;
            chord_q   <= chord_d;
            gate_q    <= gate_d;
            overrun_q <= overrun_d;
        end
    end

    for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
        slot_counter #(.DUR_W(DUR_W)) u_slot (
            .clk        (clk),
            .reset      (reset),
            .flush_i    (flush),
            .load_i     (load_vec[k]),
            .load_val_i (dur_q),
            .beat_i     (beat),
            .play_i     (play),
            .count_o    (cnt[k]),
            .busy_o     (slot_busy[k]),
            .release_o  (slot_release[k])
        );
    end

    assign slot_load     = load_vec;
    assign slot_note     = note_q;
    assign slot_duration = dur_q;
    assign note_done     = (state_q == S_DONE);
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_note_slot_scheduler.sv
// Scoreboard bench: stimulus queues expected load/release/done events with
// their cycle; a negedge monitor pops and compares every event the DUT shows.
module tb_note_slot_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       flush = 1'b0;
    logic       play = 1'b1;
    logic       beat = 1'b0;
    logic       new_note = 1'b0;
    logic [5:0] note = '0;
    logic [5:0] duration = '0;
    logic       chord_next = 1'b0;
    logic [2:0] slot_load, slot_busy, slot_release;
    logic [5:0] slot_note, slot_duration;
    logic       note_done, overrun;

    note_slot_scheduler dut (
        .clk(clk), .reset(reset), .flush(flush), .play(play), .beat(beat),
        .new_note(new_note), .note(note), .duration(duration),
        .chord_next(chord_next), .slot_load(slot_load), .slot_note(slot_note),
        .slot_duration(slot_duration), .slot_busy(slot_busy),
        .slot_release(slot_release), .note_done(note_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [2:0] ld;
        logic [2:0] rel;
        logic       done;
        logic [5:0] nt;
        logic [5:0] du;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   chk_cnt = 0;
    int   pass_cnt = 0;

    task automatic push(input int c, input logic [2:0] ld, input logic [2:0] rel,
                        input logic done, input logic [5:0] nt, input logic [5:0] du);
        exp_t x;
        x.cyc = c; x.ld = ld; x.rel = rel; x.done = done; x.nt = nt; x.du = du;
        sb.push_back(x);
    endtask

    always @(negedge clk) begin
        if (reset && (slot_load != 3'b0 || slot_release != 3'b0 || note_done)) begin
            chk_cnt++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_event cyc=%0d load=%b rel=%b done=%b",
                         cyc, slot_load, slot_release, note_done);
            end else begin
                e = sb.pop_front();
                if (e.cyc == cyc && slot_load === e.ld && slot_release === e.rel &&
                    note_done === e.done &&
                    (e.ld == 3'b0 || (slot_note === e.nt && slot_duration === e.du)))
                    pass_cnt++;
                else
                    $display("FAIL event: got cyc=%0d load=%b rel=%b done=%b note=%0d dur=%0d, expected cyc=%0d load=%b rel=%b done=%b note=%0d dur=%0d",
                             cyc, slot_load, slot_release, note_done, slot_note, slot_duration,
                             e.cyc, e.ld, e.rel, e.done, e.nt, e.du);
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        chk_cnt++;
        if (act === expv) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [5:0] n, input logic [5:0] d, input logic ch);
        new_note = 1'b1; note = n; duration = d; chord_next = ch;
        step();
        new_note = 1'b0; note = '0; duration = '0; chord_next = 1'b0;
    endtask

    // One beat every other cycle: beat i (from 0) lands in cycle start+2*i.
    task automatic beats(input int n);
        for (int i = 0; i < n; i++) begin
            beat = 1'b1; step();
            beat = 1'b0; step();
        end
    endtask

    // Chord note: load in the cycle after the request, note_done one later.
    task automatic chord(input logic [5:0] n, input logic [5:0] d, input logic [2:0] ld);
        int c;
        c = cyc;
        push(c + 1, ld, 3'b000, 1'b0, n, d);
        push(c + 2, 3'b000, 3'b000, 1'b1, 6'd0, 6'd0);
        send(n, d, 1'b1);
        step(); step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c;
        step(); step();
        check("reset_load",    32'(slot_load), 32'h0);
        check("reset_busy",    32'(slot_busy), 32'h0);
        check("reset_done",    32'(note_done), 32'h0);
        check("reset_overrun", 32'(overrun),   32'h0);
        reset = 1'b1;
        step();

        // single note, 4 beats; release and gate empty on the 4th beat
        c = cyc;
        push(c + 1, 3'b001, 3'b000, 1'b0, 6'd10, 6'd4);
        push(c + 8, 3'b000, 3'b001, 1'b0, 6'd0, 6'd0);
        push(c + 9, 3'b000, 3'b000, 1'b1, 6'd0, 6'd0);
        send(6'd10, 6'd4, 1'b0);
        step();
        beats(4);
        check("t1_busy_after", 32'(slot_busy), 32'h0);

        // three-note chord, dur 8 each; all expire together
        chord(6'd20, 6'd8, 3'b001);
        chord(6'd21, 6'd8, 3'b010);
        c = cyc;
        push(c + 1,  3'b100, 3'b000, 1'b0, 6'd22, 6'd8);
        push(c + 16, 3'b000, 3'b111, 1'b0, 6'd0, 6'd0);
        push(c + 17, 3'b000, 3'b000, 1'b1, 6'd0, 6'd0);
        send(6'd22, 6'd8, 1'b0);
        step();
        check("t2_busy_all", 32'(slot_busy), 32'h7);
        beats(8);

        // counts 5,2,2 with play frozen; dur-6 note steals slot 1
        play = 1'b0;
        chord(6'd30, 6'd5, 3'b001);
        chord(6'd31, 6'd2, 3'b010);
        chord(6'd32, 6'd2, 3'b100);
        check("t3_busy_all", 32'(slot_busy), 32'h7);
        chord(6'd33, 6'd6, 3'b010);
        check("t3_busy_steal", 32'(slot_busy), 32'h7);
        play = 1'b1;
        c = cyc;
        push(c + 2,  3'b000, 3'b100, 1'b0, 6'd0, 6'd0);
        push(c + 8,  3'b000, 3'b001, 1'b0, 6'd0, 6'd0);
        push(c + 10, 3'b000, 3'b010, 1'b0, 6'd0, 6'd0);
        beats(6);
        check("t3_overrun", 32'(overrun), 32'h0);

        // rest note with a long note still sounding in slot 0
        chord(6'd40, 6'd20, 3'b001);
        c = cyc;
        push(c + 7, 3'b000, 3'b000, 1'b1, 6'd0, 6'd0);
        send(6'd0, 6'd3, 1'b0);
        step();
        beats(3);
        check("t4_busy", 32'(slot_busy), 32'h1);

        // play=0 freeze in WAIT: 2 beats, 10 frozen beats, 2 more beats
        c = cyc;
        push(c + 1, 3'b010, 3'b000, 1'b0, 6'd41, 6'd4);
        send(6'd41, 6'd4, 1'b0);
        step();
        beats(2);
        play = 1'b0;
        beats(10);
        check("t5_busy_frozen", 32'(slot_busy), 32'h3);
        play = 1'b1;
        c = cyc;
        push(c + 2, 3'b000, 3'b010, 1'b0, 6'd0, 6'd0);
        push(c + 3, 3'b000, 3'b000, 1'b1, 6'd0, 6'd0);
        beats(2);

        // overrun during WAIT, then flush
        c = cyc;
        push(c + 1, 3'b010, 3'b000, 1'b0, 6'd42, 6'd5);
        send(6'd42, 6'd5, 1'b0);
        step();
        send(6'd50, 6'd7, 1'b1);
        check("t6_overrun_set", 32'(overrun), 32'h1);
        step();
        check("t6_overrun_hold", 32'(overrun), 32'h1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t6_flush_busy",    32'(slot_busy),     32'h0);
        check("t6_flush_overrun", 32'(overrun),       32'h0);
        check("t6_flush_note",    32'(slot_note),     32'h0);
        check("t6_flush_dur",     32'(slot_duration), 32'h0);
        check("t6_flush_done",    32'(note_done),     32'h0);
        step();
        chord(6'd44, 6'd2, 3'b001);

        // async reset in the middle of LOAD
        send(6'd45, 6'd3, 1'b0);
        check("t6_load_before_rst", 32'(slot_load), 32'h2);
        reset = 1'b0;
        #1;
        check("t6_load_after_rst", 32'(slot_load), 32'h0);
        check("t6_busy_after_rst", 32'(slot_busy), 32'h0);
        step();
        reset = 1'b1;
        step(); step(); step();

        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
